// File: rtl/booth_seq_div_pkg.sv
// Shared definitions for the sequential signed divider: state encodings
// and the default operand width used by both booth_mul and booth_seq_div.
package booth_seq_div_pkg;

  localparam int N_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/booth_seq_div_if.sv
// Start/done request bus of the divider. The requester drives the operands
// and start; the divider returns ready, the done pulse and the results.
interface booth_seq_div_if
  import booth_seq_div_pkg::*;
#(
  parameter int n = N_DEF
);

  localparam int len = 2 * n;

  logic           start;
  logic [len-1:0] dividend;
  logic [n-1:0]   divisor;
  logic           ready;
  logic           done;
  logic [n-1:0]   quotient;
  logic [n-1:0]   remainder;
  logic           ovf;
  logic           dz;

  modport master (
    output start, dividend, divisor,
    input  ready, done, quotient, remainder, ovf, dz
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, done, quotient, remainder, ovf, dz
  );

endinterface

// File: rtl/booth_seq_div_step.sv
// One radix-2 non-restoring iteration: shifts the next dividend bit into the
// signed partial remainder and adds or subtracts the divisor magnitude
// depending on the sign of the incoming remainder.
module nr_div_step
  import booth_seq_div_pkg::*;
#(
  parameter int n = N_DEF
) (
  input  logic [n:0]   r_in,
  input  logic         shift_bit,
  input  logic [n-1:0] d_mag,
  output logic [n:0]   r_out,
  output logic         q_bit
);

  logic [n:0] r2;
  logic [n:0] dext;
  logic [n:0] sum;

  // The remainder stays within [-|D|, |D|), so n+1 bit wrap-around arithmetic is exact.
  always_comb begin
    r2    = {r_in[n-1:0], shift_bit};
    dext  = {1'b0, d_mag};
    sum   = r_in[n] ? (r2 + dext) : (r2 - dext);
    r_out = sum;
    q_bit = ~sum[n];
  end

endmodule

// File: rtl/booth_seq_div.sv
// Sequential signed divider: 2n-bit dividend by n-bit divisor, one quotient
// bit per clock using non-restoring iteration. Divide-by-zero and quotients
// that cannot fit are detected up front when possible so they finish early.
module booth_seq_div
  import booth_seq_div_pkg::*;
#(
  parameter int n = N_DEF
) (
  input logic            clk,
  input logic            rst,
  booth_seq_div_if.slave bus
);

  localparam int len = 2 * n;
  localparam int cw  = $clog2(n + 1);

  localparam logic [n-1:0] QMAX_POS = {1'b0, {(n-1){1'b1}}};
  localparam logic [n-1:0] QMAX_NEG = {1'b1, {(n-1){1'b0}}};

  logic [1:0]    state;
  logic [cw-1:0] cnt;
  logic [n:0]    rem_r;
  logic [n-1:0]  lo_r;
  logic [n-1:0]  dmag_r;
  logic          sign_q;
  logic          sign_r;

  logic [n-1:0]  quo_o;
  logic [n-1:0]  rem_o;
  logic          ovf_o;
  logic          dz_o;
  logic          ready;

  logic [len-1:0] a_abs;
  logic [n-1:0]   d_abs;
  logic [n:0]     r_step;
  logic           q_step;
  logic [n-1:0]   r_mag;
  logic [n-1:0]   q_fin;
  logic [n-1:0]   r_fin;
  logic           fix_ovf;

  assign ready         = (state == ST_IDLE) | (state == ST_DONE);
  assign bus.ready     = ready;
  assign bus.done      = (state == ST_DONE);
  assign bus.quotient  = quo_o;
  assign bus.remainder = rem_o;
  assign bus.ovf       = ovf_o;
  assign bus.dz        = dz_o;

  // Operand magnitudes; the most negative value maps onto its unsigned magnitude.
  always_comb begin
    a_abs = bus.dividend[len-1] ? (-bus.dividend) : bus.dividend;
    d_abs = bus.divisor[n-1] ? (-bus.divisor) : bus.divisor;
  end

  nr_div_step #(.n(n)) u_step (
    .r_in      (rem_r),
    .shift_bit (lo_r[n-1]),
    .d_mag     (dmag_r),
    .r_out     (r_step),
    .q_bit     (q_step)
  );

  // Final remainder correction, sign application and quotient range check.
  always_comb begin
    r_mag   = rem_r[n] ? (rem_r[n-1:0] + dmag_r) : rem_r[n-1:0];
    fix_ovf = sign_q ? (lo_r > QMAX_NEG) : (lo_r > QMAX_POS);
    q_fin   = sign_q ? (-lo_r) : lo_r;
    r_fin   = sign_r ? (-r_mag) : r_mag;
  end

  // Control FSM; lo_r holds the low dividend half and fills with quotient bits as it shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      rem_r  <= '0;
      lo_r   <= '0;
      dmag_r <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      quo_o  <= '0;
      rem_o  <= '0;
      ovf_o  <= 1'b0;
      dz_o   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            sign_q <= bus.dividend[len-1] ^ bus.divisor[n-1];
            sign_r <= bus.dividend[len-1];
            dmag_r <= d_abs;
            rem_r  <= {1'b0, a_abs[len-1:n]};
            lo_r   <= a_abs[n-1:0];
            cnt    <= '0;
            if (bus.divisor == '0) begin
              state <= ST_DONE;
              dz_o  <= 1'b1;
              ovf_o <= 1'b0;
              quo_o <= '1;
              rem_o <= bus.dividend[n-1:0];
            end else if (a_abs[len-1:n] >= d_abs) begin
              state <= ST_DONE;
              dz_o  <= 1'b0;
              ovf_o <= 1'b1;
              quo_o <= '0;
              rem_o <= '0;
            end else begin
              state <= ST_RUN;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          rem_r <= r_step;
          lo_r  <= {lo_r[n-2:0], q_step};
          cnt   <= cnt + cw'(1);
          if (cnt == cw'(n - 1)) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          quo_o <= fix_ovf ? '0 : q_fin;
          rem_o <= fix_ovf ? '0 : r_fin;
          ovf_o <= fix_ovf;
          dz_o  <= 1'b0;
          state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_div.sv
// Directed and randomized checks for booth_seq_div with n=8.
module tb_booth_seq_div;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  booth_seq_div_if #(.n(8)) bus ();

  booth_seq_div #(.n(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Issue one request and wait (bounded) for its done pulse; lat counts cycles after accept.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                        output logic [7:0] q, output logic [7:0] r,
                        output logic o, output logic z, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = a;
    bus.divisor = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = -1;
    q = '0;
    r = '0;
    o = 1'b0;
    z = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = c;
        q = bus.quotient;
        r = bus.remainder;
        o = bus.ovf;
        z = bus.dz;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({bus.ready, bus.done, bus.quotient, bus.remainder, bus.ovf, bus.dz} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got rdy=%b done=%b q=%h r=%h ovf=%b dz=%b, want rdy=1 done=0 q=00 r=00 ovf=0 dz=0",
               bus.ready, bus.done, bus.quotient, bus.remainder, bus.ovf, bus.dz);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] q, r;
    logic o, z;
    int lat;
    run_op(16'd100, 8'd7, q, r, o, z, lat);
    tests_run++;
    if ({q, r, o, z} !== {8'd14, 8'd2, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL basic_100_7: got q=%h r=%h ovf=%b dz=%b, want q=0e r=02 ovf=0 dz=0", q, r, o, z);
    end
    tests_run++;
    if (lat !== 10) begin
      tests_failed++;
      $display("[TB] FAIL basic_latency: got %0d, want 10", lat);
    end
  endtask

  task automatic test_signs();
    logic [15:0] av [3];
    logic [7:0]  bv [3];
    logic [7:0]  qv [3];
    logic [7:0]  rv [3];
    logic [7:0] q, r;
    logic o, z;
    int lat;
    av[0] = 16'hFF9C; bv[0] = 8'd7;  qv[0] = 8'hF2; rv[0] = 8'hFE;
    av[1] = 16'd100;  bv[1] = 8'hF9; qv[1] = 8'hF2; rv[1] = 8'h02;
    av[2] = 16'hFF9C; bv[2] = 8'hF9; qv[2] = 8'h0E; rv[2] = 8'hFE;
    for (int i = 0; i < 3; i++) begin
      run_op(av[i], bv[i], q, r, o, z, lat);
      tests_run++;
      if ({q, r, o, z, lat} !== {qv[i], rv[i], 1'b0, 1'b0, 32'sd10}) begin
        tests_failed++;
        $display("[TB] FAIL signs_%0d: got q=%h r=%h ovf=%b dz=%b lat=%0d, want q=%h r=%h ovf=0 dz=0 lat=10",
                 i, q, r, o, z, lat, qv[i], rv[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] q, r;
    logic o, z;
    int lat;
    run_op(16'hFC00, 8'd8, q, r, o, z, lat);
    tests_run++;
    if ({q, r, o, z, lat} !== {8'h80, 8'h00, 1'b0, 1'b0, 32'sd10}) begin
      tests_failed++;
      $display("[TB] FAIL ovf_neg_bound: got q=%h r=%h ovf=%b dz=%b lat=%0d, want q=80 r=00 ovf=0 dz=0 lat=10", q, r, o, z, lat);
    end
    run_op(16'h0400, 8'd8, q, r, o, z, lat);
    tests_run++;
    if ({q, r, o, z, lat} !== {8'h00, 8'h00, 1'b1, 1'b0, 32'sd10}) begin
      tests_failed++;
      $display("[TB] FAIL ovf_post_check: got q=%h r=%h ovf=%b dz=%b lat=%0d, want q=00 r=00 ovf=1 dz=0 lat=10", q, r, o, z, lat);
    end
    run_op(16'h8000, 8'hFF, q, r, o, z, lat);
    tests_run++;
    if ({q, r, o, z, lat} !== {8'h00, 8'h00, 1'b1, 1'b0, 32'sd1}) begin
      tests_failed++;
      $display("[TB] FAIL ovf_pre_check: got q=%h r=%h ovf=%b dz=%b lat=%0d, want q=00 r=00 ovf=1 dz=0 lat=1", q, r, o, z, lat);
    end
  endtask

  task automatic test_div_zero();
    logic [7:0] q, r;
    logic o, z;
    int lat;
    run_op(16'h1234, 8'h00, q, r, o, z, lat);
    tests_run++;
    if ({q, r, o, z, lat} !== {8'hFF, 8'h34, 1'b0, 1'b1, 32'sd1}) begin
      tests_failed++;
      $display("[TB] FAIL div_zero: got q=%h r=%h ovf=%b dz=%b lat=%0d, want q=ff r=34 ovf=0 dz=1 lat=1", q, r, o, z, lat);
    end
  endtask

  task automatic test_reset_in_run();
    int seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 16'd100;
    bus.divisor = 8'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({bus.ready, bus.done, bus.quotient, bus.remainder, bus.ovf, bus.dz} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_run: got rdy=%b done=%b q=%h r=%h ovf=%b dz=%b, want rdy=1 done=0 q=00 r=00 ovf=0 dz=0",
               bus.ready, bus.done, bus.quotient, bus.remainder, bus.ovf, bus.dz);
    end
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done !== 1'b0) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_no_done: got %0d done cycles, want 0", seen);
    end
  endtask

  task automatic test_ignored_start();
    int lat;
    int seen;
    logic [7:0] q, r;
    logic o, z;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 16'd100;
    bus.divisor = 8'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = -1;
    q = '0; r = '0; o = 1'b0; z = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 3) begin
        bus.start = 1'b1;
        bus.dividend = 16'h0500;
        bus.divisor = 8'h00;
      end
      if (c == 4) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        lat = c;
        q = bus.quotient; r = bus.remainder; o = bus.ovf; z = bus.dz;
        break;
      end
    end
    tests_run++;
    if ({q, r, o, z, lat} !== {8'd14, 8'd2, 1'b0, 1'b0, 32'sd10}) begin
      tests_failed++;
      $display("[TB] FAIL ignored_start: got q=%h r=%h ovf=%b dz=%b lat=%0d, want q=0e r=02 ovf=0 dz=0 lat=10", q, r, o, z, lat);
    end
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done !== 1'b0) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("[TB] FAIL ignored_not_queued: got %0d extra done cycles, want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int lat1;
    int lat2;
    logic [7:0] q1, r1, q2, r2;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 16'd100;
    bus.divisor = 8'd7;
    @(posedge clk);
    #1;
    bus.dividend = 16'hFF9C;
    lat1 = -1; q1 = '0; r1 = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat1 = c; q1 = bus.quotient; r1 = bus.remainder;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat2 = -1; q2 = '0; r2 = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat2 = c; q2 = bus.quotient; r2 = bus.remainder;
        break;
      end
    end
    tests_run++;
    if ({q1, r1, lat1} !== {8'd14, 8'd2, 32'sd10}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: got q=%h r=%h lat=%0d, want q=0e r=02 lat=10", q1, r1, lat1);
    end
    tests_run++;
    if ({q2, r2, lat2} !== {8'hF2, 8'hFE, 32'sd10}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: got q=%h r=%h lat=%0d, want q=f2 r=fe lat=10", q2, r2, lat2);
    end
  endtask

  task automatic test_back_to_back_early();
    logic [2:0] d;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 16'h0005;
    bus.divisor = 8'h00;
    @(posedge clk);
    #1;
    @(negedge clk);
    d[2] = bus.done;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    d[1] = bus.done;
    @(negedge clk);
    d[0] = bus.done;
    tests_run++;
    if (d !== 3'b110) begin
      tests_failed++;
      $display("[TB] FAIL b2b_early_done: got done sequence %b, want 110", d);
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [7:0] b, q, r, eq, er;
    logic o, z, eo, ez;
    int lat, ai, bi, amag, bmag, qi, ri;
    for (int k = 0; k < 400; k++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 3) != 0) a = $signed(a) >>> $urandom_range(1, 9);
      b = 8'($urandom);
      ai = $signed(a);
      bi = $signed(b);
      eo = 1'b0; ez = 1'b0; eq = '0; er = '0;
      if (bi == 0) begin
        ez = 1'b1; eq = 8'hFF; er = a[7:0];
      end else begin
        amag = (ai < 0) ? -ai : ai;
        bmag = (bi < 0) ? -bi : bi;
        if ((amag >> 8) >= bmag) begin
          eo = 1'b1;
        end else begin
          qi = ai / bi;
          ri = ai % bi;
          if (qi > 127 || qi < -128) eo = 1'b1;
          else begin
            eq = qi[7:0];
            er = ri[7:0];
          end
        end
      end
      run_op(a, b, q, r, o, z, lat);
      tests_run++;
      if ({q, r, o, z} !== {eq, er, eo, ez} || lat < 1) begin
        tests_failed++;
        $display("[TB] FAIL random_%0d a=%h b=%h: got q=%h r=%h ovf=%b dz=%b lat=%0d, want q=%h r=%h ovf=%b dz=%b",
                 k, a, b, q, r, o, z, lat, eq, er, eo, ez);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    test_reset();
    test_basic();
    test_signs();
    test_overflow();
    test_div_zero();
    test_reset_in_run();
    test_ignored_start();
    test_back_to_back();
    test_back_to_back_early();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
